// File: rtl/mem_pkg.sv
// Shared types and helpers for the block-fill responder.
// MEM_WRITE_EN adds the WRITE state used by block writes.
package mem_pkg;

   localparam logic [31:0] INIT_PATTERN = 32'hD00D0000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_BURST = 2'd2
`ifdef MEM_WRITE_EN
      ,
      ST_WRITE = 2'd3
`endif
   } state_t;

   function automatic int beats_of(input int block_size, input int data_width);
      return block_size / (data_width / 8);
   endfunction

   function automatic int byte_sel_width(input int data_width);
      return $clog2(data_width / 8);
   endfunction

   function automatic int offset_width(input int block_size);
      return $clog2(block_size);
   endfunction

   function automatic int word_sel_width(input int beats);
      return $clog2(beats);
   endfunction

endpackage

// File: rtl/mem_word_array.sv
// Word storage preset to the init pattern; combinational read.
// Writable only when MEM_WRITE_EN is defined, otherwise a fixed table.
module mem_word_array
   import mem_pkg::*;
#(
   parameter int AW = 9,
   parameter int DW = 32
) (
   input  logic          clk,
`ifdef MEM_WRITE_EN
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
`endif
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

`ifdef MEM_WRITE_EN
   localparam int WORDS = 1 << AW;

   typedef logic [DW-1:0] mem_t [WORDS];

   function automatic mem_t init_words();
      mem_t w;
      for (int i = 0; i < WORDS; i++) begin
         w[i] = DW'(INIT_PATTERN | 32'(i));
      end
      return w;
   endfunction

   mem_t mem = init_words();

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];
`else
   // Contents can never change, so each word is just its init value.
   logic unused_clk;
   assign unused_clk = clk;
   assign rdata = DW'(INIT_PATTERN | 32'(raddr));
`endif

endmodule

// File: rtl/mem_fill_responder.sv
// Critical-word-first block-fill responder with fixed access latency.
// Define MEM_WRITE_EN to add block writes (req_write / wr_* ports).
module mem_fill_responder
   import mem_pkg::*;
#(
   parameter int ADDR_WIDTH  = 11,
   parameter int DATA_WIDTH  = 32,
   parameter int BLOCK_SIZE  = 16,
   parameter int MEM_LATENCY = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [ADDR_WIDTH-1:0] req_addr,
`ifdef MEM_WRITE_EN
   input  logic                  req_write,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [DATA_WIDTH-1:0] wr_data,
`endif
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [DATA_WIDTH-1:0] resp_data,
   output logic                  resp_last
);

   localparam int BEATS   = beats_of(BLOCK_SIZE, DATA_WIDTH);
   localparam int BYTE_W  = byte_sel_width(DATA_WIDTH);
   localparam int OFF_W   = offset_width(BLOCK_SIZE);
   localparam int WSEL_W  = word_sel_width(BEATS);
   localparam int WORD_AW = ADDR_WIDTH - BYTE_W;
   localparam int BLK_W   = ADDR_WIDTH - OFF_W;

   localparam logic [3:0]        LAT      = 4'(MEM_LATENCY);
   localparam logic [WSEL_W-1:0] LAST_SEL = WSEL_W'(BEATS - 1);
   localparam logic              ONE_BEAT = (BEATS == 1);

   state_t              state;
   logic [3:0]          lat_cnt;
   logic [BLK_W-1:0]    blk;
   logic [WSEL_W-1:0]   crit;
   logic [WSEL_W-1:0]   beat;

   logic [WSEL_W-1:0]   nxt_beat;
   logic [WSEL_W-1:0]   rd_sel;
   logic [WORD_AW-1:0]  rd_idx;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                last_beat;
   logic                resp_fire;
   logic                req_fire;
   logic                unused_lsb;

   assign nxt_beat  = beat + 1'b1;
   assign last_beat = (beat == LAST_SEL);
   assign resp_fire = resp_valid & resp_ready;
   assign req_fire  = req_valid & req_ready;
   assign unused_lsb = ^req_addr[BYTE_W-1:0];

   // In IDLE the critical word is read straight from req_addr so a
   // zero-latency request can load beat 0 on its acceptance edge.
   assign rd_sel = crit + ((state == ST_BURST) ? nxt_beat : '0);
   assign rd_idx = (state == ST_IDLE) ?
                   req_addr[ADDR_WIDTH-1:BYTE_W] : {blk, rd_sel};

`ifdef MEM_WRITE_EN
   logic                 wr_fire;
   logic [WSEL_W-1:0]    wr_sel;

   assign wr_fire = wr_valid & wr_ready;
   assign wr_sel  = crit + beat;
`endif

   mem_word_array #(
      .AW (WORD_AW),
      .DW (DATA_WIDTH)
   ) u_array (
      .clk   (clk),
`ifdef MEM_WRITE_EN
      .we    (wr_fire),
      .waddr ({blk, wr_sel}),
      .wdata (wr_data),
`endif
      .raddr (rd_idx),
      .rdata (rd_data)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_last  <= 1'b0;
         resp_data  <= '0;
         lat_cnt    <= '0;
         blk        <= '0;
         crit       <= '0;
         beat       <= '0;
`ifdef MEM_WRITE_EN
         wr_ready   <= 1'b0;
`endif
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (req_fire) begin
                  blk       <= req_addr[ADDR_WIDTH-1:OFF_W];
                  crit      <= req_addr[OFF_W-1:BYTE_W];
                  beat      <= '0;
                  req_ready <= 1'b0;
`ifdef MEM_WRITE_EN
                  if (req_write) begin
                     state    <= ST_WRITE;
                     wr_ready <= 1'b1;
                  end else
`endif
                  if (LAT == 4'd0) begin
                     state      <= ST_BURST;
                     resp_valid <= 1'b1;
                     resp_data  <= rd_data;
                     resp_last  <= ONE_BEAT;
                  end else begin
                     state   <= ST_WAIT;
                     lat_cnt <= LAT;
                  end
               end
            end
            ST_WAIT: begin
               if (lat_cnt == 4'd1) begin
                  state      <= ST_BURST;
                  lat_cnt    <= '0;
                  resp_valid <= 1'b1;
                  resp_data  <= rd_data;
                  resp_last  <= ONE_BEAT;
               end else begin
                  lat_cnt <= lat_cnt - 4'd1;
               end
            end
            ST_BURST: begin
               if (resp_fire) begin
                  if (last_beat) begin
                     state      <= ST_IDLE;
                     req_ready  <= 1'b1;
                     resp_valid <= 1'b0;
                     resp_last  <= 1'b0;
                     resp_data  <= '0;
                     beat       <= '0;
                  end else begin
                     beat      <= nxt_beat;
                     resp_data <= rd_data;
                     resp_last <= (nxt_beat == LAST_SEL);
                  end
               end
            end
`ifdef MEM_WRITE_EN
            // Beat stays at the last index so the single ack beat
            // retires through the normal BURST exit.
            ST_WRITE: begin
               if (wr_fire) begin
                  if (last_beat) begin
                     state      <= ST_BURST;
                     wr_ready   <= 1'b0;
                     resp_valid <= 1'b1;
                     resp_data  <= '0;
                     resp_last  <= 1'b1;
                  end else begin
                     beat <= nxt_beat;
                  end
               end
            end
`endif
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_fill_responder.sv
// Self-checking bench for mem_fill_responder: vector table, corner
// sequences and random reads against a block-level memory model.
module tb_mem_fill_responder;

   localparam int LAT = 4;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [10:0] req_addr;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_data;
   logic        resp_last;
`ifdef MEM_WRITE_EN
   logic        req_write;
   logic        wr_valid;
   logic        wr_ready;
   logic [31:0] wr_data;
`endif

   int checks = 0;
   int errors = 0;

   logic [31:0] model_mem [512];

   mem_fill_responder #(
      .ADDR_WIDTH  (11),
      .DATA_WIDTH  (32),
      .BLOCK_SIZE  (16),
      .MEM_LATENCY (LAT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_addr   (req_addr),
`ifdef MEM_WRITE_EN
      .req_write  (req_write),
      .wr_valid   (wr_valid),
      .wr_ready   (wr_ready),
      .wr_data    (wr_data),
`endif
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .resp_last  (resp_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %h required %h", name, act, exp);
      end
   endtask

   // Expected beats from the memory model: critical word first,
   // wrapping inside the 16-byte block.
   function automatic logic [3:0][31:0] model_block(input logic [10:0] a);
      logic [3:0][31:0] e;
      int base;
      int crit;
      base = (int'(a) / 16) * 4;
      crit = (int'(a) / 4) % 4;
      for (int k = 0; k < 4; k++) begin
         e[k] = model_mem[base + (crit + k) % 4];
      end
      return e;
   endfunction

   task automatic read_txn(input logic [10:0] addr, input logic [15:0] stalls,
                           input logic [3:0][31:0] exp);
      int cyc;
      int n;
      logic [31:0] held;
      @(negedge clk);
      check("req_ready_idle", 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_addr  = addr;
      resp_ready = 1'b0;
`ifdef MEM_WRITE_EN
      req_write = 1'b0;
`endif
      @(negedge clk);
      req_valid = 1'b0;
      check("req_ready_busy", 32'(req_ready), 32'd0);
      cyc = 0;
      while (!resp_valid && cyc < 64) begin
         @(negedge clk);
         cyc++;
      end
      check("latency", 32'(cyc), 32'(LAT));
      if (!resp_valid) return;
      for (int k = 0; k < 4; k++) begin
         n = int'(stalls[4*k +: 4]);
         held = resp_data;
         for (int s = 0; s < n; s++) begin
            @(negedge clk);
            check("hold_valid", 32'(resp_valid), 32'd1);
            check("hold_data", resp_data, held);
         end
         check("beat_valid", 32'(resp_valid), 32'd1);
         check("beat_data", resp_data, exp[k]);
         check("beat_last", 32'(resp_last), 32'(k == 3));
         resp_ready = 1'b1;
         @(negedge clk);
         resp_ready = 1'b0;
      end
      check("valid_after", 32'(resp_valid), 32'd0);
      check("ready_after", 32'(req_ready), 32'd1);
   endtask

`ifdef MEM_WRITE_EN
   task automatic write_txn(input logic [10:0] addr,
                            input logic [3:0][31:0] beats);
      int cyc;
      int base;
      int crit;
      base = (int'(addr) / 16) * 4;
      crit = (int'(addr) / 4) % 4;
      @(negedge clk);
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = addr;
      @(negedge clk);
      req_valid = 1'b0;
      req_write = 1'b0;
      for (int k = 0; k < 4; k++) begin
         cyc = 0;
         while (!wr_ready && cyc < 32) begin
            @(negedge clk);
            cyc++;
         end
         check("wr_ready", 32'(wr_ready), 32'd1);
         wr_valid = 1'b1;
         wr_data  = beats[k];
         model_mem[base + (crit + k) % 4] = beats[k];
         @(negedge clk);
         wr_valid = 1'b0;
      end
      cyc = 0;
      while (!resp_valid && cyc < 32) begin
         @(negedge clk);
         cyc++;
      end
      check("wr_ack_valid", 32'(resp_valid), 32'd1);
      check("wr_ack_data", resp_data, 32'd0);
      check("wr_ack_last", 32'(resp_last), 32'd1);
      check("wr_ready_low", 32'(wr_ready), 32'd0);
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      check("wr_idle", 32'(req_ready), 32'd1);
   endtask
`endif

   typedef struct {
      logic [10:0]       addr;
      logic [15:0]       stalls;
      logic [3:0][31:0]  exp;
   } vec_t;

   vec_t vecs [6];

   initial begin
      int cyc;
      logic [10:0] ra;
      logic [15:0] rs;

      for (int i = 0; i < 512; i++) begin
         model_mem[i] = 32'hD00D0000 | 32'(i);
      end

      vecs[0] = '{11'h040, 16'h0000,
                  {32'hD00D0013, 32'hD00D0012, 32'hD00D0011, 32'hD00D0010}};
      vecs[1] = '{11'h04C, 16'h0000,
                  {32'hD00D0012, 32'hD00D0011, 32'hD00D0010, 32'hD00D0013}};
      vecs[2] = '{11'h040, 16'h0030,
                  {32'hD00D0013, 32'hD00D0012, 32'hD00D0011, 32'hD00D0010}};
      vecs[3] = '{11'h7F8, 16'h2101,
                  {32'hD00D01FD, 32'hD00D01FC, 32'hD00D01FF, 32'hD00D01FE}};
      vecs[4] = '{11'h003, 16'h0000,
                  {32'hD00D0003, 32'hD00D0002, 32'hD00D0001, 32'hD00D0000}};
      vecs[5] = '{11'h127, 16'h1020,
                  {32'hD00D0048, 32'hD00D004B, 32'hD00D004A, 32'hD00D0049}};

      rst        = 1'b1;
      req_valid  = 1'b0;
      req_addr   = '0;
      resp_ready = 1'b0;
`ifdef MEM_WRITE_EN
      req_write  = 1'b0;
      wr_valid   = 1'b0;
      wr_data    = '0;
`endif
      #1;
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_resp_data", resp_data, 32'd0);
      check("rst_resp_last", 32'(resp_last), 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 6; i++) begin
         read_txn(vecs[i].addr, vecs[i].stalls, vecs[i].exp);
      end

      // Reset in the second beat aborts the burst.
      @(negedge clk);
      req_valid = 1'b1;
      req_addr  = 11'h040;
      @(negedge clk);
      req_valid = 1'b0;
      cyc = 0;
      while (!resp_valid && cyc < 64) begin
         @(negedge clk);
         cyc++;
      end
      check("abort_first", resp_data, 32'hD00D0010);
      resp_ready = 1'b1;
      @(negedge clk);
      check("abort_second", resp_data, 32'hD00D0011);
      rst = 1'b1;
      resp_ready = 1'b0;
      #1;
      check("abort_valid", 32'(resp_valid), 32'd0);
      check("abort_ready", 32'(req_ready), 32'd1);
      check("abort_data", resp_data, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      resp_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("abort_quiet", 32'(resp_valid), 32'd0);
      end
      resp_ready = 1'b0;
      read_txn(11'h040, 16'h0000, model_block(11'h040));

`ifdef MEM_WRITE_EN
      write_txn(11'h080,
                {32'h000000A3, 32'h000000A2, 32'h000000A1, 32'h000000A0});
      read_txn(11'h080, 16'h0000,
               {32'h000000A3, 32'h000000A2, 32'h000000A1, 32'h000000A0});
      write_txn(11'h0B8,
                {32'h5555_0003, 32'h5555_0002, 32'h5555_0001, 32'h5555_0000});
      read_txn(11'h0B4, 16'h0102, model_block(11'h0B4));
`endif

      for (int t = 0; t < 25; t++) begin
         ra = 11'($urandom_range(0, 2047));
         rs = '0;
         for (int k = 0; k < 4; k++) begin
            rs[4*k +: 4] = 4'($urandom_range(0, 3));
         end
         read_txn(ra, rs, model_block(ra));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
